// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC operation sequencer.
//   - op codes carried in CTRL[1:0]
//   - codeword width codes carried in CODEWORD_WIDTH[1:0]
//   - sequencer FSM state type
//   - width_mask(): message/codeword mask for a width code
//   - ERR_TIMEOUT: num_of_errors value reported on an encoder/decoder timeout
package ecc_pkg;

    localparam logic [1:0] OP_ENC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_FULL = 2'b10;
    localparam logic [1:0] OP_NONE = 2'b11;

    localparam logic [1:0] WIDTH_8   = 2'b00;
    localparam logic [1:0] WIDTH_16  = 2'b01;
    localparam logic [1:0] WIDTH_32  = 2'b10;
    localparam logic [1:0] WIDTH_RSV = 2'b11;

    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StEncGo,
        StEncWait,
        StNoise,
        StDecGo,
        StDecWait,
        StDone
    } state_e;

    // Reserved code 11 behaves as 32-bit.
    function automatic logic [31:0] width_mask(input logic [1:0] width);
        case (width)
            WIDTH_8:  width_mask = 32'h0000_00FF;
            WIDTH_16: width_mask = 32'h0000_FFFF;
            default:  width_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/ecc_timeout_cnt.sv
// Wait-state timeout counter.
//   clk     in   clock, rising edge
//   rst     in   asynchronous, active-low reset
//   clr     in   synchronous clear (asserted in the cycle before a wait state)
//   en      in   count enable (asserted in every wait-state cycle)
//   expired out  high in the TIMEOUT_CYC-th consecutive enabled cycle after a clear
module ecc_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CntW'(TIMEOUT_CYC))) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of enabled cycles already elapsed, so this flags the last one.
    assign expired = en && (cnt_q == CntW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ecc_op_sequencer.sv
// Operation controller between the APB register bank and the ECC encoder/decoder.
// Latches CTRL/DATA_IN/CODEWORD_WIDTH/NOISE once per command and runs encode, decode
// or full channel (encode, XOR noise, decode), then reports the result with a done pulse.
//   clk, rst                    clock / asynchronous active-low reset
//   cmd_stb                     CTRL write strobe (starts a command when idle)
//   ctrl, data_in,
//   codeword_width, noise       register bank contents, sampled in the LOAD cycle
//   enc_start/enc_word          encoder request; enc_done/enc_codeword encoder reply
//   dec_start/dec_word          decoder request; dec_done/dec_data/dec_num_err decoder reply
//   cw_width                    latched width code for encoder/decoder
//   data_out, num_of_errors     result, held until the next operation_done
//   operation_done              one-cycle pulse when the result updates
//   busy                        command in progress
module ecc_op_sequencer
    import ecc_pkg::*;
#(
    parameter int unsigned AMBA_WORD   = 32,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_stb,
    input  logic [AMBA_WORD-1:0] ctrl,
    input  logic [AMBA_WORD-1:0] data_in,
    input  logic [AMBA_WORD-1:0] codeword_width,
    input  logic [AMBA_WORD-1:0] noise,
    output logic                 enc_start,
    output logic [AMBA_WORD-1:0] enc_word,
    input  logic                 enc_done,
    input  logic [AMBA_WORD-1:0] enc_codeword,
    output logic                 dec_start,
    output logic [AMBA_WORD-1:0] dec_word,
    input  logic                 dec_done,
    input  logic [AMBA_WORD-1:0] dec_data,
    input  logic [1:0]           dec_num_err,
    output logic [1:0]           cw_width,
    output logic [AMBA_WORD-1:0] data_out,
    output logic [1:0]           num_of_errors,
    output logic                 operation_done,
    output logic                 busy
);

    state_e state_q, state_d;

    logic [1:0]           op_q, op_d;
    logic [1:0]           width_q, width_d;
    logic [AMBA_WORD-1:0] word_q, word_d;
    logic [AMBA_WORD-1:0] noise_q, noise_d;
    logic [1:0]           err_q, err_d;
    logic [AMBA_WORD-1:0] data_out_q, data_out_d;
    logic [1:0]           num_err_q, num_err_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic                 cnt_clr, cnt_en, expired;
    logic [1:0]           width_sel;
    logic [AMBA_WORD-1:0] mask_in, mask_q;

    logic unused_bits;
    assign unused_bits = ^{ctrl[AMBA_WORD-1:2], codeword_width[AMBA_WORD-1:2]};

    assign width_sel = (codeword_width[1:0] == WIDTH_RSV) ? WIDTH_32 : codeword_width[1:0];
    assign mask_in   = AMBA_WORD'(width_mask(width_sel));
    assign mask_q    = AMBA_WORD'(width_mask(width_q));

    ecc_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. busy_q also covers the done-pulse cycle, so a strobe there is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (cmd_stb && !busy_q) state_d = StLoad;
            end
            StLoad: begin
                case (ctrl[1:0])
                    OP_ENC, OP_FULL: state_d = StEncGo;
                    OP_DEC:          state_d = StDecGo;
                    default:         state_d = StIdle;
                endcase
            end
            StEncGo: state_d = StEncWait;
            StEncWait: begin
                if (enc_done) begin
                    state_d = (op_q == OP_FULL) ? StNoise : StDone;
                end else if (expired) begin
                    state_d = StDone;
                end
            end
            StNoise: state_d = StDecGo;
            StDecGo: state_d = StDecWait;
            StDecWait: begin
                if (dec_done || expired) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State-decoded outputs. The counter is cleared in each GO cycle so it reads 0 on WAIT entry.
    always_comb begin
        enc_start = (state_q == StEncGo);
        dec_start = (state_q == StDecGo);
        cnt_clr   = (state_q == StEncGo) || (state_q == StDecGo);
        cnt_en    = (state_q == StEncWait) || (state_q == StDecWait);
    end

    // Operand and result latches. A timeout leaves word 0 / error 11 for the DONE cycle.
    always_comb begin
        op_d       = op_q;
        width_d    = width_q;
        word_d     = word_q;
        noise_d    = noise_q;
        err_d      = err_q;
        data_out_d = data_out_q;
        num_err_d  = num_err_q;
        done_d     = 1'b0;
        busy_d     = (state_d != StIdle) || (state_q != StIdle);
        case (state_q)
            StLoad: begin
                op_d    = ctrl[1:0];
                width_d = width_sel;
                word_d  = data_in & mask_in;
                noise_d = noise & mask_in;
                err_d   = 2'b00;
            end
            StEncWait: begin
                if (enc_done) begin
                    word_d = enc_codeword & mask_q;
                end else if (expired) begin
                    word_d = '0;
                    err_d  = ERR_TIMEOUT;
                end
            end
            StNoise: word_d = word_q ^ noise_q;
            StDecWait: begin
                if (dec_done) begin
                    word_d = dec_data & mask_q;
                    err_d  = dec_num_err;
                end else if (expired) begin
                    word_d = '0;
                    err_d  = ERR_TIMEOUT;
                end
            end
            StDone: begin
                data_out_d = word_q;
                num_err_d  = err_q;
                done_d     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q       <= 2'b00;
            width_q    <= 2'b00;
            word_q     <= '0;
            noise_q    <= '0;
            err_q      <= 2'b00;
            data_out_q <= '0;
            num_err_q  <= 2'b00;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            op_q       <= op_d;
            width_q    <= width_d;
            word_q     <= word_d;
            noise_q    <= noise_d;
            err_q      <= err_d;
            data_out_q <= data_out_d;
            num_err_q  <= num_err_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign enc_word       = word_q;
    assign dec_word       = word_q;
    assign cw_width       = width_q;
    assign data_out       = data_out_q;
    assign num_of_errors  = num_err_q;
    assign operation_done = done_q;
    assign busy           = busy_q;

endmodule
